tlb_maint_ctrl: RTL and testbench

Sequencer for the TLB maintenance instructions TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB. It accepts one request at a time from the backend/CSR stage. It drives the write, read, invalidate and data-side search ports of the TLB subsystem, then returns a single response. It is the initiator of the TLB write/read/invalidate interface and borrows the data-side search port for TLBSRCH.

---
 rtl/tlb_maint_ctrl_pkg.sv | 50 +++++
 rtl/tlb_maint_ctrl_fill.sv | 49 ++++
 rtl/tlb_maint_ctrl.sv | 179 +++++++++++++++++
 tb/tb_tlb_maint_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_maint_ctrl_pkg.sv
// Shared types for the TLB maintenance sequencer: entry/result layouts,
// TLB geometry, maintenance op encodings and the sequencer state set.
package tlb_maint_ctrl_pkg;

  localparam int unsigned TLBNUM   = 16;
  localparam int unsigned TLBIDLEN = 4;

  typedef enum logic [2:0] {
    TLBOP_SRCH = 3'd0,
    TLBOP_RD   = 3'd1,
    TLBOP_WR   = 3'd2,
    TLBOP_FILL = 3'd3,
    TLBOP_INV  = 3'd4
  } tlb_op_e;

  // Highest INVTLB op code that is architecturally defined.
  localparam logic [4:0] INVOP_MAX = 5'd6;

  typedef struct packed {
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    logic        e;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic                found;
    logic [TLBIDLEN-1:0] index;
  } tlb_result_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RD_WAIT,
    ST_SRCH_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/tlb_maint_ctrl_fill.sv
// TLBFILL index generator. Round-robin counter by default; define
// TLB_FILL_LFSR_EN to use a 16-bit Fibonacci LFSR (taps 16,14,13,11).
module tlb_fill_index_gen
  import tlb_maint_ctrl_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                advance,
  output logic [TLBIDLEN-1:0] index
);

`ifdef TLB_FILL_LFSR_EN
  logic [15:0] lfsr;
  logic        feedback;

  assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign index    = lfsr[TLBIDLEN-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= SEED;
    end else if (advance) begin
      lfsr <= {lfsr[14:0], feedback};
    end
  end
`else
  logic [TLBIDLEN-1:0] rr;

  assign index = rr;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr <= '0;
    end else if (advance) begin
      rr <= (rr == TLBIDLEN'(TLBNUM - 1)) ? '0 : rr + 1'b1;
    end
  end
`endif

  // An all-zero seed would lock the LFSR.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (SEED != 16'h0) else $error("fill LFSR seed must be nonzero");
    end
  end

endmodule

// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance sequencer (TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB).
// Fill index source selected by macro TLB_FILL_LFSR_EN (see tlb_fill_index_gen).
module tlb_maint_ctrl
  import tlb_maint_ctrl_pkg::*;
#(
  parameter int unsigned SRCH_TIMEOUT = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [TLBIDLEN-1:0] req_index,
  input  tlb_entry_t          req_entry,
  input  logic [4:0]          req_invop,
  input  logic [9:0]          req_inv_asid,
  input  logic [31:0]         req_inv_va,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_found,
  output logic [TLBIDLEN-1:0] resp_index,
  output tlb_entry_t          resp_entry,
  output logic                resp_ine,
  output logic                srch_active,
  output logic [18:0]         s_vppn,
  output logic                s_va_bit12,
  output logic [9:0]          s_asid,
  input  tlb_result_t         s_result,
  input  logic                s_ok,
  output logic                we,
  output logic [TLBIDLEN-1:0] w_index,
  output tlb_entry_t          w_entry,
  output logic [TLBIDLEN-1:0] r_index,
  input  tlb_entry_t          r_entry,
  output logic                invtlb_valid,
  output logic [4:0]          invtlb_op,
  output logic [9:0]          invtlb_asid,
  output logic [31:0]         invtlb_va
);

  localparam logic [3:0] TMO_LAST = 4'(SRCH_TIMEOUT - 1);

  state_e              state, state_nxt;
  tlb_op_e             op_q;
  logic [3:0]          srch_cnt;
  logic                accept;
  logic                illegal;
  logic                timeout;
  logic                fill_advance;
  logic [TLBIDLEN-1:0] fill_index;

  assign req_ready    = (state == ST_IDLE);
  assign resp_valid   = (state == ST_RESP);
  assign s_va_bit12   = 1'b0;
  assign accept       = req_valid & req_ready;
  assign illegal      = (req_op > TLBOP_INV) ||
                        ((req_op == TLBOP_INV) && (req_invop > INVOP_MAX));
  assign timeout      = (srch_cnt >= TMO_LAST);
  assign fill_advance = accept & ~illegal & (req_op == TLBOP_FILL);

  tlb_fill_index_gen #(
    .SEED (LFSR_SEED)
  ) u_fill_gen (
    .clk     (clk),
    .reset   (reset),
    .advance (fill_advance),
    .index   (fill_index)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = illegal ? ST_RESP : ST_EXEC;
      end
      ST_EXEC: begin
        case (op_q)
          TLBOP_RD:   state_nxt = ST_RD_WAIT;
          TLBOP_SRCH: state_nxt = ST_SRCH_WAIT;
          default:    state_nxt = ST_RESP;
        endcase
      end
      ST_RD_WAIT:   state_nxt = ST_RESP;
      ST_SRCH_WAIT: begin
        if (s_ok || timeout) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // TLB-facing outputs are loaded on the accept edge so the pulses land in EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q         <= TLBOP_SRCH;
      srch_cnt     <= '0;
      resp_found   <= 1'b0;
      resp_index   <= '0;
      resp_entry   <= '0;
      resp_ine     <= 1'b0;
      srch_active  <= 1'b0;
      s_vppn       <= '0;
      s_asid       <= '0;
      we           <= 1'b0;
      w_index      <= '0;
      w_entry      <= '0;
      r_index      <= '0;
      invtlb_valid <= 1'b0;
      invtlb_op    <= '0;
      invtlb_asid  <= '0;
      invtlb_va    <= '0;
    end else begin
      we           <= 1'b0;
      invtlb_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q       <= tlb_op_e'(req_op);
            srch_cnt   <= '0;
            resp_found <= 1'b0;
            resp_index <= '0;
            resp_entry <= '0;
            resp_ine   <= illegal;
            if (!illegal) begin
              case (tlb_op_e'(req_op))
                TLBOP_WR: begin
                  we      <= 1'b1;
                  w_index <= req_index;
                  w_entry <= req_entry;
                end
                TLBOP_FILL: begin
                  we         <= 1'b1;
                  w_index    <= fill_index;
                  w_entry    <= req_entry;
                  resp_index <= fill_index;
                end
                TLBOP_INV: begin
                  invtlb_valid <= 1'b1;
                  invtlb_op    <= req_invop;
                  invtlb_asid  <= req_inv_asid;
                  invtlb_va    <= req_inv_va;
                end
                TLBOP_RD:   r_index <= req_index;
                TLBOP_SRCH: begin
                  s_vppn <= req_entry.vppn;
                  s_asid <= req_entry.asid;
                end
                default: ;
              endcase
            end
          end
        end
        ST_EXEC:    srch_active <= (op_q == TLBOP_SRCH);
        ST_RD_WAIT: resp_entry  <= r_entry;
        ST_SRCH_WAIT: begin
          if (s_ok || timeout) begin
            resp_found  <= s_ok & s_result.found;
            resp_index  <= (s_ok && s_result.found) ? s_result.index : '0;
            srch_active <= 1'b0;
            s_vppn      <= '0;
            s_asid      <= '0;
          end else if (srch_cnt != 4'hF) begin
            srch_cnt <= srch_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Directed bench for tlb_maint_ctrl: vector table plus multi-cycle sequences.
module tb_tlb_maint_ctrl;
  import tlb_maint_ctrl_pkg::*;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic [2:0]          req_op = '0;
  logic [TLBIDLEN-1:0] req_index = '0;
  tlb_entry_t          req_entry = '0;
  logic [4:0]          req_invop = '0;
  logic [9:0]          req_inv_asid = '0;
  logic [31:0]         req_inv_va = '0;
  logic                resp_valid;
  logic                resp_ready = 1'b0;
  logic                resp_found;
  logic [TLBIDLEN-1:0] resp_index;
  tlb_entry_t          resp_entry;
  logic                resp_ine;
  logic                srch_active;
  logic [18:0]         s_vppn;
  logic                s_va_bit12;
  logic [9:0]          s_asid;
  tlb_result_t         s_result = '0;
  logic                s_ok = 1'b0;
  logic                we;
  logic [TLBIDLEN-1:0] w_index;
  tlb_entry_t          w_entry;
  logic [TLBIDLEN-1:0] r_index;
  tlb_entry_t          r_entry;
  logic                invtlb_valid;
  logic [4:0]          invtlb_op;
  logic [9:0]          invtlb_asid;
  logic [31:0]         invtlb_va;

  tlb_maint_ctrl #(.SRCH_TIMEOUT(8), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_index(req_index), .req_entry(req_entry), .req_invop(req_invop),
    .req_inv_asid(req_inv_asid), .req_inv_va(req_inv_va),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_found(resp_found),
    .resp_index(resp_index), .resp_entry(resp_entry), .resp_ine(resp_ine),
    .srch_active(srch_active), .s_vppn(s_vppn), .s_va_bit12(s_va_bit12),
    .s_asid(s_asid), .s_result(s_result), .s_ok(s_ok),
    .we(we), .w_index(w_index), .w_entry(w_entry),
    .r_index(r_index), .r_entry(r_entry),
    .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
    .invtlb_asid(invtlb_asid), .invtlb_va(invtlb_va)
  );

  always #5 clk = ~clk;

  // TLB array model: write on we, read data one cycle after r_index.
  tlb_entry_t mem [TLBNUM];
  always @(posedge clk) begin
    if (we) mem[w_index] <= w_entry;
    r_entry <= mem[r_index];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic tlb_entry_t mk_entry(input logic [18:0] vppn);
    tlb_entry_t t;
    t = '0;
    t.vppn = vppn;  t.ps = 6'd12;  t.e = 1'b1;  t.asid = 10'h03A;
    t.ppn0 = {1'b0, vppn};  t.plv0 = 2'd3;  t.d0 = 1'b1;  t.v0 = 1'b1;
    t.ppn1 = {1'b1, vppn};  t.mat1 = 2'd1;  t.v1 = 1'b1;
    return t;
  endfunction

  // Per-transaction observations.
  int          lat, we_n, inv_n, wait_n, bad_key, sok_at;
  logic [3:0]  seen_widx;
  tlb_entry_t  seen_wentry;
  logic [4:0]  seen_iop;
  logic [9:0]  seen_iasid;
  logic [31:0] seen_iva;
  logic        got_found, got_ine, hold_ok, srch_at_resp;
  logic [3:0]  got_index;
  tlb_entry_t  got_entry;

  task automatic run_req(input logic [2:0] op, input logic [3:0] idx, input tlb_entry_t ent,
                         input logic [4:0] invop, input logic [9:0] asid, input logic [31:0] va);
    lat = 0; we_n = 0; inv_n = 0; wait_n = 0; bad_key = 0;
    @(negedge clk);
    req_op = op; req_index = idx; req_entry = ent;
    req_invop = invop; req_inv_asid = asid; req_inv_va = va;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    for (int c = 0; c < 40 && !resp_valid; c++) begin
      if (we) begin we_n++; seen_widx = w_index; seen_wentry = w_entry; end
      if (invtlb_valid) begin
        inv_n++; seen_iop = invtlb_op; seen_iasid = invtlb_asid; seen_iva = invtlb_va;
      end
      if (srch_active) begin
        wait_n++;
        if (s_vppn !== ent.vppn || s_asid !== ent.asid || s_va_bit12 !== 1'b0) bad_key++;
        s_ok = (wait_n == sok_at);
      end else begin
        s_ok = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    s_ok = 1'b0;
    if (!resp_valid) lat = 99;
    srch_at_resp = srch_active;
    got_found = resp_found; got_index = resp_index; got_entry = resp_entry; got_ine = resp_ine;
    @(posedge clk); #1;
    if (we) we_n++;
    if (invtlb_valid) inv_n++;
    hold_ok = resp_valid && resp_found === got_found && resp_index === got_index &&
              resp_entry === got_entry && resp_ine === got_ine && !req_ready;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [3:0]  idx;
    logic [18:0] vppn;
    logic [4:0]  invop;
    logic [9:0]  asid;
    logic [31:0] va;
    int          exp_lat;
    logic        exp_ine;
    int          exp_we;
    int          exp_inv;
    logic [3:0]  exp_widx;
    logic [3:0]  exp_ridx;
  } vec_t;

  function automatic vec_t mk_vec(input string n, input logic [2:0] op, input logic [3:0] idx,
                                  input logic [18:0] vppn, input logic [4:0] invop,
                                  input logic [9:0] asid, input logic [31:0] va, input int l,
                                  input logic ine, input int wn, input int iv,
                                  input logic [3:0] widx, input logic [3:0] ridx);
    vec_t v;
    v.name = n; v.op = op; v.idx = idx; v.vppn = vppn; v.invop = invop; v.asid = asid;
    v.va = va; v.exp_lat = l; v.exp_ine = ine; v.exp_we = wn; v.exp_inv = iv;
    v.exp_widx = widx; v.exp_ridx = ridx;
    return v;
  endfunction

  vec_t vecs [10];
  int   quiet;

  initial begin
    vecs[0] = mk_vec("wr5",    3'd2, 4'd5, 19'h12345, 5'd0, 10'h0,   32'h0,         2, 1'b0, 1, 0, 4'd5, 4'd0);
    vecs[1] = mk_vec("inv_op7",3'd4, 4'd0, 19'h0,     5'd7, 10'h3,   32'h80001000,  1, 1'b1, 0, 0, 4'd0, 4'd0);
    vecs[2] = mk_vec("op6",    3'd6, 4'd2, 19'h0,     5'd0, 10'h0,   32'h0,         1, 1'b1, 0, 0, 4'd0, 4'd0);
    vecs[3] = mk_vec("op7",    3'd7, 4'd9, 19'h7,     5'd1, 10'h0,   32'h0,         1, 1'b1, 0, 0, 4'd0, 4'd0);
    vecs[4] = mk_vec("inv5",   3'd4, 4'd0, 19'h0,     5'd5, 10'h3,   32'h80001000,  2, 1'b0, 0, 1, 4'd0, 4'd0);
    vecs[5] = mk_vec("inv6",   3'd4, 4'd0, 19'h0,     5'd6, 10'h155, 32'h12345000,  2, 1'b0, 0, 1, 4'd0, 4'd0);
    vecs[6] = mk_vec("fill0",  3'd3, 4'd9, 19'h00100, 5'd0, 10'h0,   32'h0,         2, 1'b0, 1, 0, 4'd0, 4'd0);
    vecs[7] = mk_vec("fill1",  3'd3, 4'd9, 19'h00101, 5'd0, 10'h0,   32'h0,         2, 1'b0, 1, 0, 4'd1, 4'd1);
    vecs[8] = mk_vec("fill2",  3'd3, 4'd9, 19'h00102, 5'd0, 10'h0,   32'h0,         2, 1'b0, 1, 0, 4'd2, 4'd2);
    vecs[9] = mk_vec("fill3",  3'd3, 4'd9, 19'h00103, 5'd0, 10'h0,   32'h0,         2, 1'b0, 1, 0, 4'd3, 4'd3);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_pulses", {we, invtlb_valid, srch_active}, 3'b000);
    chk("rst_fields", {resp_found, resp_index, resp_ine, w_index, r_index, s_vppn}, '0);

    sok_at = 0;
    for (int i = 0; i < 10; i++) begin
      run_req(vecs[i].op, vecs[i].idx, mk_entry(vecs[i].vppn), vecs[i].invop, vecs[i].asid, vecs[i].va);
      chk({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
      chk({vecs[i].name, "_ine"}, got_ine, vecs[i].exp_ine);
      chk({vecs[i].name, "_we_n"}, we_n, vecs[i].exp_we);
      chk({vecs[i].name, "_inv_n"}, inv_n, vecs[i].exp_inv);
      chk({vecs[i].name, "_resp_index"}, got_index, vecs[i].exp_ridx);
      chk({vecs[i].name, "_found_entry"}, {got_found, got_entry}, '0);
      chk({vecs[i].name, "_hold"}, hold_ok, 1'b1);
      chk({vecs[i].name, "_idle"}, req_ready, 1'b1);
      if (vecs[i].exp_we != 0) begin
        chk({vecs[i].name, "_w_index"}, seen_widx, vecs[i].exp_widx);
        chk({vecs[i].name, "_w_entry"}, seen_wentry, mk_entry(vecs[i].vppn));
      end
      if (vecs[i].exp_inv != 0) begin
        chk({vecs[i].name, "_inv_fields"}, {seen_iop, seen_iasid, seen_iva},
            {vecs[i].invop, vecs[i].asid, vecs[i].va});
      end
    end

    // TLBRD of the entry written at index 5.
    run_req(3'd1, 4'd5, '0, 5'd0, 10'h0, 32'h0);
    chk("rd5_lat", lat, 3);
    chk("rd5_entry", got_entry, mk_entry(19'h12345));
    chk("rd5_flags", {got_found, got_ine, got_index, we_n[3:0]}, '0);

    // TLBSRCH hit, s_ok in the third wait cycle.
    s_result.found = 1'b1; s_result.index = 4'd5; sok_at = 3;
    run_req(3'd0, 4'd0, mk_entry(19'h12345), 5'd0, 10'h0, 32'h0);
    chk("srch3_lat", lat, 5);
    chk("srch3_found", got_found, 1'b1);
    chk("srch3_index", got_index, 4'd5);
    chk("srch3_key_stable", bad_key, 0);
    chk("srch3_active_at_resp", srch_at_resp, 1'b0);
    chk("srch3_hold", hold_ok, 1'b1);

    // s_ok in the very first wait cycle.
    s_result.index = 4'd11; sok_at = 1;
    run_req(3'd0, 4'd0, mk_entry(19'h0ABCD), 5'd0, 10'h0, 32'h0);
    chk("srch1_lat", lat, 3);
    chk("srch1_result", {got_found, got_index}, {1'b1, 4'd11});

    // No s_ok: timeout after exactly 8 wait cycles.
    sok_at = 0;
    run_req(3'd0, 4'd0, mk_entry(19'h12345), 5'd0, 10'h0, 32'h0);
    chk("srch_tmo_waits", wait_n, 8);
    chk("srch_tmo_lat", lat, 10);
    chk("srch_tmo_result", {got_found, got_index}, '0);
    chk("srch_tmo_key_stable", bad_key, 0);

    // s_ok in the same cycle as timeout: the hit wins.
    s_result.index = 4'd7; sok_at = 8;
    run_req(3'd0, 4'd0, mk_entry(19'h54321), 5'd0, 10'h0, 32'h0);
    chk("srch_race_lat", lat, 10);
    chk("srch_race_result", {got_found, got_index}, {1'b1, 4'd7});
    sok_at = 0;

    // Continue filling from 4 through 15, then wrap to 0.
    for (int i = 0; i < 13; i++) begin
      run_req(3'd3, 4'd0, mk_entry(19'h00200 + 19'(i)), 5'd0, 10'h0, 32'h0);
      chk($sformatf("fill_wrap_%0d", i), {seen_widx, got_index}, {2{4'((4 + i) % 16)}});
    end

    // Reset during SRCH_WAIT abandons the search with no response.
    @(negedge clk);
    req_op = 3'd0; req_entry = mk_entry(19'h12345); req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_in_srch", srch_active, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_req_ready", req_ready, 1'b1);
    chk("mid_rst_outputs", {resp_valid, srch_active, s_vppn, we, invtlb_valid}, '0);
    @(negedge clk);
    reset = 1'b0;
    quiet = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (resp_valid || !req_ready) quiet++;
    end
    chk("mid_rst_no_resp", quiet, 0);

    // Fill generator restarts from 0 after reset.
    run_req(3'd3, 4'd0, mk_entry(19'h00300), 5'd0, 10'h0, 32'h0);
    chk("fill_after_rst", {seen_widx, got_index, we_n[1:0]}, {4'd0, 4'd0, 2'd1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
